// File: rtl/bus_ctrl.sv
// bus_ctrl: physical-memory bus controller between the CPU data-bus port and
// a synchronous single-port word-wide SRAM with byte enables.
// One access at a time (fetch/load/store). Completion is signalled by a
// registered one-cycle db_ready pulse; bus_err accompanies it on rejection.
// Optional feature macro: BUS_CTRL_ALIGN_CHECK_EN (rejects misaligned H/W).
//
// Handshake: a request is taken only while the FSM is in IDLE and
// db_accessType != NONE; the CPU must drop db_accessType combinationally in
// the cycle db_ready is high. Inputs are ignored in every non-IDLE state.

package bus_ctrl_pkg;
  typedef enum logic [1:0] {
    MEM_ACCESS_NONE = 2'd0,
    MEM_ACCESS_R    = 2'd1,
    MEM_ACCESS_W    = 2'd2,
    MEM_ACCESS_X    = 2'd3
  } MEM_ACCESS_T;

  typedef enum logic [1:0] {
    MEM_LEN_B = 2'd0,
    MEM_LEN_H = 2'd1,
    MEM_LEN_W = 2'd2
  } MEM_LEN;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;
endpackage

module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int AW          = 14,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              res,
  input  logic [31:0]       db_addr,
  input  logic [31:0]       db_dataOut,
  input  MEM_ACCESS_T       db_accessType,
  input  MEM_LEN            db_memLen,
  output logic [31:0]       db_dataIn,
  output logic              db_ready,
  output logic              bus_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output state_t            dbg_state
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t        r_state;
  state_t        w_next;
  logic [AW+1:0] r_addr;
  MEM_LEN        r_len;
  logic          r_is_wr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_data;
  logic [3:0]    r_cnt;
  logic          r_ready;
  logic          r_err;

  logic          w_req;
  logic          w_range_err;
  logic          w_align_err;
  logic          w_reject;
  MEM_LEN        w_len_eff;
  logic [1:0]    w_off;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rdata_al;

  // Request acceptance and rejection decode (only meaningful in IDLE).
  always_comb begin
    w_req     = (r_state == ST_IDLE) && (db_accessType != MEM_ACCESS_NONE);
    // Fetches are always word reads; an undefined length code is treated as a word.
    w_len_eff = db_memLen;
    if ((db_accessType == MEM_ACCESS_X) ||
        ((db_memLen != MEM_LEN_B) && (db_memLen != MEM_LEN_H))) begin
      w_len_eff = MEM_LEN_W;
    end
    // Anything above the decoded 2^(AW+2)-byte window is rejected.
    w_range_err = (db_addr >> (AW + 2)) != 32'd0;
`ifdef BUS_CTRL_ALIGN_CHECK_EN
    w_align_err = ((w_len_eff == MEM_LEN_H) && db_addr[0]) ||
                  ((w_len_eff == MEM_LEN_W) && (db_addr[1:0] != 2'b00));
`else
    // Without the check, misaligned H/W are silently forced aligned by the lane logic.
    w_align_err = 1'b0;
`endif
    w_reject = w_range_err || w_align_err;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next = w_reject ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS: w_next = ST_WAIT;
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP:   w_next = ST_IDLE;
      ST_ERR:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Byte-lane steering for writes and right-alignment of read data.
  always_comb begin
    w_off      = r_addr[1:0];
    w_be       = 4'b1111;
    w_wdata    = r_wdata;
    w_rdata_al = mem_rdata;
    case (r_len)
      MEM_LEN_B: begin
        w_be       = 4'b0001 << w_off;
        w_wdata    = {4{r_wdata[7:0]}};
        w_rdata_al = (mem_rdata >> {w_off, 3'b000}) & 32'h0000_00FF;
      end
      MEM_LEN_H: begin
        // addr[0] is ignored: halfword lanes are selected by addr[1] only.
        w_be       = 4'b0011 << {w_off[1], 1'b0};
        w_wdata    = {2{r_wdata[15:0]}};
        w_rdata_al = (mem_rdata >> {w_off[1], 4'b0000}) & 32'h0000_FFFF;
      end
      default: begin
        w_be       = 4'b1111;
        w_wdata    = r_wdata;
        w_rdata_al = mem_rdata;
      end
    endcase
  end

  // SRAM port drive: active only in ACCESS, so mem_en lasts exactly one cycle
  // and every SRAM output is zero in reset and in all other states.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (r_state == ST_ACCESS) begin
      mem_en    = 1'b1;
      mem_we    = r_is_wr;
      mem_addr  = r_addr[AW+1:2];
      mem_be    = r_is_wr ? w_be : 4'b1111;
      mem_wdata = r_is_wr ? w_wdata : 32'd0;
    end
  end

  // State register; async reset aborts any access in flight.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the request attributes when it is taken in IDLE.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_addr  <= '0;
      r_len   <= MEM_LEN_B;
      r_is_wr <= 1'b0;
      r_wdata <= 32'd0;
    end else if (w_req) begin
      r_addr  <= db_addr[AW+1:0];
      r_len   <= w_len_eff;
      r_is_wr <= (db_accessType == MEM_ACCESS_W);
      r_wdata <= db_dataOut;
    end
  end

  // WAIT-state counter: loaded while in ACCESS so WAIT lasts WAIT_CYCLES+1 cycles.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_cnt <= 4'd0;
    end else if (r_state == ST_ACCESS) begin
      r_cnt <= WAIT_LD;
    end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Registered response: ready/err pulse and the returned data word.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= 32'd0;
    end else begin
      r_ready <= (w_next == ST_RESP) || (w_next == ST_ERR);
      r_err   <= (w_next == ST_ERR);
      if (w_next == ST_ERR) begin
        r_data <= 32'd0;
      end else if ((r_state == ST_WAIT) && (r_cnt == 4'd0)) begin
        r_data <= r_is_wr ? 32'd0 : w_rdata_al;
      end
    end
  end

  assign db_ready  = r_ready;
  assign bus_err   = r_err;
  assign db_dataIn = r_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_ctrl.sv
// Testbench for bus_ctrl: directed vectors, scoreboard queues popped by
// response monitors, an SRAM model per DUT instance (WAIT_CYCLES=0 and 3).
module tb_bus_ctrl;
  import bus_ctrl_pkg::*;

  localparam int AW = 14;

  // ---------------- clock / reset ----------------
  logic clk;
  logic res;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT 0 (WAIT_CYCLES=0) ----------------
  logic [31:0]   db_addr;
  logic [31:0]   db_dataOut;
  MEM_ACCESS_T   db_accessType;
  MEM_LEN        db_memLen;
  logic [31:0]   db_dataIn;
  logic          db_ready;
  logic          bus_err;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  state_t        dbg_state;

  bus_ctrl #(.AW(AW), .WAIT_CYCLES(0)) u_dut (
    .clk(clk), .res(res),
    .db_addr(db_addr), .db_dataOut(db_dataOut),
    .db_accessType(db_accessType), .db_memLen(db_memLen),
    .db_dataIn(db_dataIn), .db_ready(db_ready), .bus_err(bus_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT 3 (WAIT_CYCLES=3) ----------------
  logic [31:0]   d3_addr;
  logic [31:0]   d3_dataOut;
  MEM_ACCESS_T   d3_accessType;
  MEM_LEN        d3_memLen;
  logic [31:0]   d3_dataIn;
  logic          d3_ready;
  logic          d3_err;
  logic          d3_en;
  logic          d3_we;
  logic [3:0]    d3_be;
  logic [AW-1:0] d3_maddr;
  logic [31:0]   d3_wdata;
  logic [31:0]   d3_rdata;
  state_t        d3_state;

  bus_ctrl #(.AW(AW), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .res(res),
    .db_addr(d3_addr), .db_dataOut(d3_dataOut),
    .db_accessType(d3_accessType), .db_memLen(d3_memLen),
    .db_dataIn(d3_dataIn), .db_ready(d3_ready), .bus_err(d3_err),
    .mem_en(d3_en), .mem_we(d3_we), .mem_be(d3_be),
    .mem_addr(d3_maddr), .mem_wdata(d3_wdata), .mem_rdata(d3_rdata),
    .dbg_state(d3_state)
  );

  // ---------------- SRAM models ----------------
  logic [31:0] sram  [0:(1<<AW)-1];
  logic [31:0] sram3 [0:15];

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = 32'd0;
    sram[128] = 32'h1122_3344;   // old contents at byte 0x200
    for (int i = 0; i < 16; i++) sram3[i] = 32'd0;
    sram3[0] = 32'h0BAD_F00D;
    mem_rdata = 32'd0;
    d3_rdata  = 32'd0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= sram[mem_addr];
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (d3_en) d3_rdata <= sram3[d3_maddr[3:0]];
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  logic [32:0] exp3_q[$];
  logic [32:0] mon_e;
  logic [32:0] mon3_e;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp_v);
  endtask

  // Response monitor for DUT 0: each db_ready pops one {bus_err, data} entry.
  always @(negedge clk) begin
    if (!res && db_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected db_ready", 32'(db_ready), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp bus_err", 32'(bus_err), 32'(mon_e[32]));
        chk("resp db_dataIn", db_dataIn, mon_e[31:0]);
      end
    end
  end

  // Response monitor for DUT 3.
  always @(negedge clk) begin
    if (!res && d3_ready) begin
      if (exp3_q.size() == 0) begin
        chk("unexpected d3 db_ready", 32'(d3_ready), 32'd0);
      end else begin
        mon3_e = exp3_q.pop_front();
        chk("d3 resp bus_err", 32'(d3_err), 32'(mon3_e[32]));
        chk("d3 resp db_dataIn", d3_dataIn, mon3_e[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one request, pushes the expected response, then follows the
  // access to check latency, mem_en pulse count and store lane steering.
  task automatic do_req(input string nm, input MEM_ACCESS_T t, input MEM_LEN l,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_rd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    int cyc;
    int en_cnt;
    logic got;
    logic [3:0] be_s;
    logic [31:0] wd_s;
    @(posedge clk); #1;
    db_accessType = t;
    db_memLen     = l;
    db_addr       = a;
    db_dataOut    = wd;
    exp_q.push_back({exp_err, exp_err ? 32'd0 : exp_rd});
    cyc = 0; en_cnt = 0; got = 1'b0; be_s = 4'd0; wd_s = 32'd0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        be_s = mem_be;
        wd_s = mem_wdata;
      end
      if (db_ready) got = 1'b1;
      else cyc++;
    end
    db_accessType = MEM_ACCESS_NONE;
    chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({nm, " mem_en cycles"}, 32'(en_cnt), exp_err ? 32'd0 : 32'd1);
    if (!exp_err) chk({nm, " mem_be"}, 32'(be_s), 32'(exp_be));
    if (!exp_err && t == MEM_ACCESS_W) chk({nm, " mem_wdata"}, wd_s, exp_wd);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int en_cnt;
    logic got;
    res = 1'b1;
    db_addr = 32'd0; db_dataOut = 32'd0;
    db_accessType = MEM_ACCESS_NONE; db_memLen = MEM_LEN_W;
    d3_addr = 32'd0; d3_dataOut = 32'd0;
    d3_accessType = MEM_ACCESS_NONE; d3_memLen = MEM_LEN_W;

    // Reset values.
    @(negedge clk);
    chk("reset ctrl outputs", 32'({db_ready, bus_err, mem_en, mem_we, mem_be}), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset db_dataIn", db_dataIn, 32'd0);
    chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1 res = 1'b0;

    // Word store then load.
    do_req("store W 0x100", MEM_ACCESS_W, MEM_LEN_W, 32'h100, 32'hDEADBEEF,
           3, 1'b0, 32'd0, 4'b1111, 32'hDEADBEEF);
    do_req("load W 0x100", MEM_ACCESS_R, MEM_LEN_W, 32'h100, 32'd0,
           3, 1'b0, 32'hDEADBEEF, 4'b1111, 32'd0);
    @(negedge clk);
    chk("db_dataIn hold after RESP", db_dataIn, 32'hDEADBEEF);

    // Byte lanes: only wdata[7:0] is replicated.
    do_req("store B 0x103", MEM_ACCESS_W, MEM_LEN_B, 32'h103, 32'h1234565A,
           3, 1'b0, 32'd0, 4'b1000, 32'h5A5A5A5A);
    do_req("load B 0x103", MEM_ACCESS_R, MEM_LEN_B, 32'h103, 32'd0,
           3, 1'b0, 32'h0000005A, 4'b1111, 32'd0);
    // Word @0x100 is now 5AADBEEF (byte lane 2 = 0xAD), so H @0x102 = 0x5AAD.
    do_req("load H 0x102", MEM_ACCESS_R, MEM_LEN_H, 32'h102, 32'd0,
           3, 1'b0, 32'h00005AAD, 4'b1111, 32'd0);
    do_req("load B 0x101", MEM_ACCESS_R, MEM_LEN_B, 32'h101, 32'd0,
           3, 1'b0, 32'h000000BE, 4'b1111, 32'd0);
    do_req("load H 0x100", MEM_ACCESS_R, MEM_LEN_H, 32'h100, 32'd0,
           3, 1'b0, 32'h0000BEEF, 4'b1111, 32'd0);
    do_req("store H 0x106", MEM_ACCESS_W, MEM_LEN_H, 32'h106, 32'hABCD1234,
           3, 1'b0, 32'd0, 4'b1100, 32'h12341234);
    do_req("load W 0x104", MEM_ACCESS_R, MEM_LEN_W, 32'h104, 32'd0,
           3, 1'b0, 32'h12340000, 4'b1111, 32'd0);
    do_req("fetch 0x100", MEM_ACCESS_X, MEM_LEN_W, 32'h100, 32'd0,
           3, 1'b0, 32'h5AADBEEF, 4'b1111, 32'd0);

    // Range error (AW=14 decodes 64 KiB).
    do_req("range err 0x10000", MEM_ACCESS_R, MEM_LEN_W, 32'h0001_0000, 32'd0,
           1, 1'b1, 32'd0, 4'b1111, 32'd0);
    do_req("range err 0x80000100", MEM_ACCESS_W, MEM_LEN_B, 32'h8000_0100, 32'hFF,
           1, 1'b1, 32'd0, 4'b1111, 32'd0);

    // Alignment.
`ifdef BUS_CTRL_ALIGN_CHECK_EN
    do_req("misaligned W 0x102", MEM_ACCESS_R, MEM_LEN_W, 32'h102, 32'd0,
           1, 1'b1, 32'd0, 4'b1111, 32'd0);
    do_req("misaligned H 0x101", MEM_ACCESS_R, MEM_LEN_H, 32'h101, 32'd0,
           1, 1'b1, 32'd0, 4'b1111, 32'd0);
`else
    do_req("unchecked W 0x102", MEM_ACCESS_R, MEM_LEN_W, 32'h102, 32'd0,
           3, 1'b0, 32'h5AADBEEF, 4'b1111, 32'd0);
    do_req("unchecked H 0x101", MEM_ACCESS_R, MEM_LEN_H, 32'h101, 32'd0,
           3, 1'b0, 32'h0000BEEF, 4'b1111, 32'd0);
`endif

    // Reset during ACCESS of a store @0x200: store must be aborted.
    @(posedge clk); #1;
    db_accessType = MEM_ACCESS_W; db_memLen = MEM_LEN_W;
    db_addr = 32'h200; db_dataOut = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("abort store in ACCESS", 32'({mem_en, mem_we}), 32'd3);
    #1 res = 1'b1;
    db_accessType = MEM_ACCESS_NONE;
    @(negedge clk);
    chk("mid reset ctrl outputs", 32'({db_ready, bus_err, mem_en, mem_we, mem_be}), 32'd0);
    chk("mid reset mem_addr", 32'(mem_addr), 32'd0);
    chk("mid reset mem_wdata", mem_wdata, 32'd0);
    chk("mid reset db_dataIn", db_dataIn, 32'd0);
    @(posedge clk); #1 res = 1'b0;
    do_req("load W 0x200 after abort", MEM_ACCESS_R, MEM_LEN_W, 32'h200, 32'd0,
           3, 1'b0, 32'h11223344, 4'b1111, 32'd0);

    // WAIT_CYCLES=3 fetch @0x0.
    @(posedge clk); #1;
    d3_accessType = MEM_ACCESS_X; d3_memLen = MEM_LEN_W; d3_addr = 32'h0;
    exp3_q.push_back({1'b0, 32'h0BADF00D});
    cyc = 0; en_cnt = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (d3_en) en_cnt++;
      if (d3_ready) got = 1'b1;
      else cyc++;
    end
    d3_accessType = MEM_ACCESS_NONE;
    chk("wait3 fetch latency", 32'(cyc), 32'd6);
    chk("wait3 fetch mem_en cycles", 32'(en_cnt), 32'd1);

    // Drain and report.
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    chk("scoreboard3 drained", 32'(exp3_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
